fadd_rev_seq: RTL and testbench

FADD_REV_SEQ -- requirements
Module: fadd_rev_seq

---
 rtl/fadd_rev_seq.sv | 187 ++++++++++++++++++
 tb/tb_fadd_rev_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_rev_seq.sv
// fadd_rev_seq: chunk-serial dual-rail adder / reversible subtractor.
// dir=0: {cout,y} = x+b+cin. dir=1: y = x-b-cin, cout = borrow-out.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   start, dir         : request (sampled in IDLE), 0=add 1=subtract
//   x/x_not, b/b_not   : dual-rail operands
//   cin/cin_not        : dual-rail carry-in / borrow-in
//   busy, done         : busy in RUN/DONE, one-cycle result pulse
//   y/y_not            : dual-rail result
//   cout/cout_not      : dual-rail carry-out / borrow-out
//   z/z_not            : dual-rail zero flag of y
//   rail_err           : sticky rail fault (only with DUALRAIL_CHECK_EN)
//
// Build option DUALRAIL_CHECK_EN: reject a start whose operand rails
// are not complementary and raise rail_err.

module fadd_rev_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] x_not,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] b_not,
  input  logic             cin,
  input  logic             cin_not,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_not,
  output logic             cout,
  output logic             cout_not,
  output logic             z,
  output logic             z_not
`ifdef DUALRAIL_CHECK_EN
  ,
  output logic             rail_err
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW =
    (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y_q;
  logic             dir_q;
  logic             c_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             last;
  logic             rail_ok;

  logic [CHUNK-1:0] xc;
  logic [CHUNK-1:0] bc;
  logic [CHUNK-1:0] sc;
  logic [CHUNK:0]   ext;
  logic             c_next;

`ifdef DUALRAIL_CHECK_EN
  assign rail_ok = (&(x ^ x_not))
                 & (&(b ^ b_not))
                 & (cin ^ cin_not);
`else
  // Complement rails carry no information
  // in this build; only true rails are used.
  logic unused_rails;
  assign unused_rails =
    ^{x_not, b_not, cin_not};
  assign rail_ok = 1'b1;
`endif

  assign last = (cnt_q == CW'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && rail_ok) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operands are shifted right so the
  // active chunk always sits at bit 0.
  // In subtract mode bit CHUNK of the
  // extended difference is the borrow.
  always_comb begin
    xc = x_q[CHUNK-1:0];
    bc = b_q[CHUNK-1:0];
    if (dir_q) begin
      ext = {1'b0, xc}
          - {1'b0, bc}
          - {{CHUNK{1'b0}}, c_q};
    end else begin
      ext = {1'b0, xc}
          + {1'b0, bc}
          + {{CHUNK{1'b0}}, c_q};
    end
    sc     = ext[CHUNK-1:0];
    c_next = ext[CHUNK];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
      dir_q    <= 1'b0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef DUALRAIL_CHECK_EN
      rail_err <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q   <= x;
        b_q   <= b;
        dir_q <= dir;
        c_q   <= cin;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        x_q <= x_q >> CHUNK;
        b_q <= b_q >> CHUNK;
        c_q <= c_next;
        y_q[int'(cnt_q)*CHUNK +: CHUNK]
          <= sc;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          cout_q <= c_next;
        end
      end
`ifdef DUALRAIL_CHECK_EN
      // Set on a rejected request,
      // cleared on an accepted one.
      if (state_q == IDLE && start) begin
        rail_err <= !rail_ok;
      end
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign y        = y_q;
  assign y_not    = ~y_q;
  assign cout     = cout_q;
  assign cout_not = ~cout_q;
  assign z        = ~|y_q;
  assign z_not    = |y_q;

endmodule

// File: tb/tb_fadd_rev_seq.sv
// tb_fadd_rev_seq: directed and round-trip
// checks of fadd_rev_seq (WIDTH=16, CHUNK=4).

module tb_fadd_rev_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dir;
  logic [15:0] x;
  logic [15:0] x_not;
  logic [15:0] b;
  logic [15:0] b_not;
  logic        cin;
  logic        cin_not;
  logic        busy;
  logic        done;
  logic [15:0] y;
  logic [15:0] y_not;
  logic        cout;
  logic        cout_not;
  logic        z;
  logic        z_not;
`ifdef DUALRAIL_CHECK_EN
  logic        rail_err;
`endif

  int nvec;
  int nerr;

  logic [15:0] cap_y;
  logic [15:0] cap_yn;
  logic        cap_c;
  logic        cap_cn;
  logic        cap_z;
  logic        cap_zn;
  int          cap_lat;
  logic        cap_bad;

  fadd_rev_seq #(
    .WIDTH(16),
    .CHUNK(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .x        (x),
    .x_not    (x_not),
    .b        (b),
    .b_not    (b_not),
    .cin      (cin),
    .cin_not  (cin_not),
    .busy     (busy),
    .done     (done),
    .y        (y),
    .y_not    (y_not),
    .cout     (cout),
    .cout_not (cout_not),
    .z        (z),
    .z_not    (z_not)
`ifdef DUALRAIL_CHECK_EN
    ,
    .rail_err (rail_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic set_in(
    input logic        d,
    input logic [15:0] xa,
    input logic [15:0] ba,
    input logic        ci
  );
    dir     = d;
    x       = xa;
    x_not   = ~xa;
    b       = ba;
    b_not   = ~ba;
    cin     = ci;
    cin_not = ~ci;
  endtask

  // Issue one request, scramble inputs after
  // acceptance, wait (bounded) for done.
  task automatic op(
    input logic        d,
    input logic [15:0] xa,
    input logic [15:0] ba,
    input logic        ci
  );
    set_in(d, xa, ba, ci);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_in(~d, ~xa, xa ^ ba, ~ci);
    cap_lat = 1;
    cap_bad = 1'b0;
    while (done !== 1'b1 && cap_lat < 20) begin
      if (y_not !== ~y || cout_not !== ~cout
          || z_not !== ~z)
        cap_bad = 1'b1;
      tick();
      cap_lat++;
    end
    if (y_not !== ~y || cout_not !== ~cout
        || z_not !== ~z)
      cap_bad = 1'b1;
    cap_y  = y;
    cap_yn = y_not;
    cap_c  = cout;
    cap_cn = cout_not;
    cap_z  = z;
    cap_zn = z_not;
    tick();
    chk("after_done", {30'd0, done, busy}, 32'd0);
  endtask

  task automatic do_op(
    input string       tag,
    input logic        d,
    input logic [15:0] xa,
    input logic [15:0] ba,
    input logic        ci,
    input logic [15:0] ey,
    input logic        ec
  );
    logic [15:0] eyn;
    logic        ecn;
    eyn = ~ey;
    ecn = ~ec;
    op(d, xa, ba, ci);
    chk({tag, ".lat"}, cap_lat, 5);
    chk({tag, ".y"}, cap_y, ey);
    chk({tag, ".yn"}, cap_yn, eyn);
    chk({tag, ".c"}, cap_c, ec);
    chk({tag, ".cn"}, cap_cn, ecn);
    chk({tag, ".z"}, cap_z, ey == 16'd0);
    chk({tag, ".zn"}, cap_zn, ey != 16'd0);
    chk({tag, ".rails"}, cap_bad, 0);
  endtask

  initial begin
    int          ndone;
    int          dcyc;
    logic [15:0] ycap;
    logic [15:0] xa;
    logic [15:0] ba;
    logic        ci;
    logic [16:0] s17;
    logic        bbad;

    nvec  = 0;
    nerr  = 0;
    rst   = 1'b1;
    start = 1'b0;
    set_in(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();
    tick();

    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.y", y, 16'h0000);
    chk("rst.yn", y_not, 16'hFFFF);
    chk("rst.c", cout, 0);
    chk("rst.cn", cout_not, 1);
    chk("rst.z", z, 1);
    chk("rst.zn", z_not, 0);
`ifdef DUALRAIL_CHECK_EN
    chk("rst.rail", rail_err, 0);
`endif

    // reset wins over start in IDLE
    set_in(1'b0, 16'h0001, 16'h0001, 1'b0);
    start = 1'b1;
    tick();
    chk("rstprio.busy", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rstprio.busy2", busy, 0);

    do_op("f00ff", 1'b0, 16'h00FF, 16'h0001,
          1'b0, 16'h0100, 1'b0);
    do_op("fffff", 1'b0, 16'hFFFF, 16'h0001,
          1'b0, 16'h0000, 1'b1);
    do_op("r0100", 1'b1, 16'h0100, 16'h0001,
          1'b0, 16'h00FF, 1'b0);
    do_op("r0000", 1'b1, 16'h0000, 16'h0001,
          1'b0, 16'hFFFF, 1'b1);
    do_op("fcin", 1'b0, 16'h1234, 16'h4321,
          1'b1, 16'h5556, 1'b0);
    do_op("rcin", 1'b1, 16'h5556, 16'h4321,
          1'b1, 16'h1234, 1'b0);
    do_op("f8000", 1'b0, 16'h8000, 16'h8000,
          1'b0, 16'h0000, 1'b1);
    do_op("r8000", 1'b1, 16'h0000, 16'h8000,
          1'b0, 16'h8000, 1'b1);
    do_op("fmax", 1'b0, 16'hFFFF, 16'hFFFF,
          1'b1, 16'hFFFF, 1'b1);
    do_op("rmax", 1'b1, 16'h0000, 16'hFFFF,
          1'b1, 16'h0000, 1'b1);

    // results hold while idle inputs wander
    do_op("hold", 1'b0, 16'h0F0F, 16'h0101,
          1'b0, 16'h1010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'hA5A5, 16'h5A5A, 1'b1);
      tick();
    end
    chk("hold.y", y, 16'h1010);
    chk("hold.c", cout, 0);
    chk("hold.busy", busy, 0);

    // start while busy is ignored
    set_in(1'b0, 16'h1234, 16'h0001, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_in(1'b0, 16'h5678, 16'h0001, 1'b0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    dcyc  = 0;
    ycap  = 16'h0000;
    for (int k = 3; k < 13; k++) begin
      if (done === 1'b1) begin
        ndone++;
        dcyc = k;
        ycap = y;
      end
      tick();
    end
    chk("busystart.ndone", ndone, 1);
    chk("busystart.cyc", dcyc, 5);
    chk("busystart.y", ycap, 16'h1235);

    // reset mid-RUN aborts
    set_in(1'b0, 16'h1111, 16'h0001, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.y", y, 16'h0000);
    chk("abort.yn", y_not, 16'hFFFF);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("abort.nodone", ndone, 0);

`ifdef DUALRAIL_CHECK_EN
    set_in(1'b0, 16'h0008, 16'h0001, 1'b0);
    x_not = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rail.err", rail_err, 1);
    chk("rail.busy", busy, 0);
    ndone = 0;
    bbad  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) ndone++;
      if (busy !== 1'b0) bbad = 1'b1;
      tick();
    end
    chk("rail.nodone", ndone, 0);
    chk("rail.idle", bbad, 0);
    chk("rail.sticky", rail_err, 1);
    do_op("railok", 1'b0, 16'h0008, 16'h0001,
          1'b0, 16'h0009, 1'b0);
    chk("rail.clear", rail_err, 0);
`endif

    // random forward then reverse round-trips
    for (int i = 0; i < 1000; i++) begin
      xa  = 16'($urandom);
      ba  = 16'($urandom);
      ci  = 1'($urandom_range(0, 1));
      s17 = {1'b0, xa} + {1'b0, ba}
          + {16'd0, ci};
      do_op("rtf", 1'b0, xa, ba, ci,
            s17[15:0], s17[16]);
      do_op("rtr", 1'b1, s17[15:0], ba, ci,
            xa, s17[16]);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
